// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encodings, FSM states, default latencies.
package mdu_sched_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_mult(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sched_if.sv
// E-stage <-> multiply/divide scheduler bundle: issue, operands, stall and HI/LO readback.
interface mdu_sched_if;
  import mdu_sched_pkg::*;

  logic        start;
  md_op_e      op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md_use;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, d_md_use,
                  input  busy, md_stall, hi, lo);
  modport slave  (input  start, op, a, b, d_md_use,
                  output busy, md_stall, hi, lo);
endinterface

// File: rtl/mdu_sched_arith.sv
// Combinational signed/unsigned 32x32 multiply and divide producing a {hi,lo} result pair.
module mdu_arith
  import mdu_sched_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  md_op_e      op,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic               a_neg, b_neg;
  logic        [31:0] a_mag, b_mag, dvsr;
  logic        [31:0] uq, ur, q, r;

  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'd0, a} * {32'd0, b};

  // Divide on magnitudes so truncation toward zero and dividend-signed
  // remainder fall out directly; 0x80000000/-1 wraps back to 0x80000000.
  assign a_neg = (op == MD_DIV) && a[31];
  assign b_neg = (op == MD_DIV) && b[31];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign dvsr  = (b == 32'd0) ? 32'd1 : b_mag;
  assign uq    = a_mag / dvsr;
  assign ur    = a_mag % dvsr;
  assign q     = (a_neg ^ b_neg) ? -uq : uq;
  assign r     = a_neg ? -ur : ur;

  assign div_by_zero = (b == 32'd0);

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    if (op == MD_MULT) begin
      res_hi = sprod[63:32];
      res_lo = sprod[31:0];
    end else if (op == MD_MULTU) begin
      res_hi = uprod[63:32];
      res_lo = uprod[31:0];
    end else if (is_div(op)) begin
      res_hi = r;
      res_lo = q;
    end
  end

endmodule

// File: rtl/mdu_sched.sv
// E-stage multiply/divide scheduler: fixed-latency down-counter, HI/LO ownership, D-stage stall request.
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  mdu_sched_if.slave  sif
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        dz_q, dz_d;
  logic [31:0] res_hi, res_lo;
  logic        div_by_zero;

  mdu_arith u_arith (
    .a           (sif.a),
    .b           (sif.b),
    .op          (sif.op),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (sif.start) begin
          if (is_mult(sif.op) || is_div(sif.op)) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            dz_d      = is_div(sif.op) && div_by_zero;
            count_d   = is_mult(sif.op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            state_d   = ST_RUN;
          end else if (sif.op == MD_MTHI) begin
            hi_d = sif.a;
          end else if (sif.op == MD_MTLO) begin
            lo_d = sif.a;
          end
        end
      end
      ST_RUN: begin
        // start is ignored here; the stall keeps a second md-op out of E.
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = ST_IDLE;
          if (!dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sif.busy     = (state_q == ST_RUN);
  assign sif.md_stall = sif.d_md_use & (sif.busy | sif.start);
  assign sif.hi       = hi_q;
  assign sif.lo       = lo_q;

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: latency, HI/LO results, divide corner cases, stall and reset abort.
module tb_mdu_sched;
  import mdu_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mdu_sched_if sif ();

  mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Protocol guard: a start while busy must never be presented.
  always @(negedge clk) begin
    if (!reset) begin
      assert (!(sif.start && sif.busy)) else begin
        bad++;
        $error("FAIL start_while_busy observed=1 expected=0");
      end
    end
  end

  // Present one md-op for cycle t; returns in cycle t+1.
  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    sif.start = 1'b1;
    sif.op    = op;
    sif.a     = a;
    sif.b     = b;
    @(negedge clk);
    sif.start = 1'b0;
    sif.op    = MD_NONE;
  endtask

  // Counts consecutive busy cycles from t+1; returns in the first non-busy cycle.
  task automatic busy_len(input string tag, input int n);
    int c = 0;
    while (sif.busy === 1'b1 && c < 40) begin
      c++;
      @(negedge clk);
    end
    chk(tag, 64'(c), 64'(n));
  endtask

  initial begin
    reset        = 1'b1;
    sif.start    = 1'b0;
    sif.op       = MD_NONE;
    sif.a        = '0;
    sif.b        = '0;
    sif.d_md_use = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(sif.busy), 64'd0);
    chk("rst_hi", 64'(sif.hi), 64'd0);
    chk("rst_lo", 64'(sif.lo), 64'd0);
    chk("rst_stall", 64'(sif.md_stall), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    busy_len("mult_busy", 5);
    chk("mult_hi", 64'(sif.hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(sif.lo), 64'hFFFF_FFFA);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi_hold", 64'(sif.hi), 64'hFFFF_FFFF);
    busy_len("multu_busy", 5);
    chk("multu_hi", 64'(sif.hi), 64'h0000_0001);
    chk("multu_lo", 64'(sif.lo), 64'hFFFF_FFFE);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    busy_len("div_busy", 10);
    chk("div_lo", 64'(sif.lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(sif.hi), 64'hFFFF_FFFF);

    issue(MD_DIVU, 32'd7, 32'd2);
    busy_len("divu_busy", 10);
    chk("divu_lo", 64'(sif.lo), 64'd3);
    chk("divu_hi", 64'(sif.hi), 64'd1);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_len("divovf_busy", 10);
    chk("divovf_lo", 64'(sif.lo), 64'h8000_0000);
    chk("divovf_hi", 64'(sif.hi), 64'd0);

    issue(MD_MTHI, 32'h11, 32'd0);
    chk("mthi_hi", 64'(sif.hi), 64'h11);
    chk("mthi_lo_keep", 64'(sif.lo), 64'h8000_0000);
    chk("mthi_busy", 64'(sif.busy), 64'd0);
    issue(MD_MTLO, 32'h22, 32'd0);
    chk("mtlo_lo", 64'(sif.lo), 64'h22);
    chk("mtlo_hi_keep", 64'(sif.hi), 64'h11);

    issue(MD_DIV, 32'd50, 32'd0);
    busy_len("dz_busy", 10);
    chk("dz_hi", 64'(sif.hi), 64'h11);
    chk("dz_lo", 64'(sif.lo), 64'h22);

    // Stall held from the issue cycle through the last busy cycle.
    sif.d_md_use = 1'b1;
    sif.start    = 1'b1;
    sif.op       = MD_MULT;
    sif.a        = 32'd6;
    sif.b        = 32'd7;
    #1;
    chk("stall_t0", 64'(sif.md_stall), 64'd1);
    @(negedge clk);
    sif.start = 1'b0;
    sif.op    = MD_NONE;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("stall_t%0d", i), 64'(sif.md_stall), 64'd1);
      @(negedge clk);
    end
    chk("stall_t6", 64'(sif.md_stall), 64'd0);
    chk("stall_mult_lo", 64'(sif.lo), 64'd42);
    sif.d_md_use = 1'b0;

    sif.start = 1'b1;
    sif.op    = MD_MULTU;
    sif.a     = 32'd3;
    sif.b     = 32'd3;
    #1;
    chk("nostall_t0", 64'(sif.md_stall), 64'd0);
    @(negedge clk);
    sif.start = 1'b0;
    sif.op    = MD_NONE;
    for (int i = 1; i <= 6; i++) begin
      chk($sformatf("nostall_t%0d", i), 64'(sif.md_stall), 64'd0);
      @(negedge clk);
    end
    chk("nostall_lo", 64'(sif.lo), 64'd9);

    // Reset during cycle t+3 of a divide abandons it.
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(sif.busy), 64'd0);
    chk("abort_hi", 64'(sif.hi), 64'd0);
    chk("abort_lo", 64'(sif.lo), 64'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_nocommit_hi", 64'(sif.hi), 64'd0);
    chk("abort_nocommit_lo", 64'(sif.lo), 64'd0);

    issue(MD_MTLO, 32'h5A, 32'd0);
    chk("post_mtlo_lo", 64'(sif.lo), 64'h5A);
    chk("post_mtlo_busy", 64'(sif.busy), 64'd0);
    @(negedge clk);
    chk("post_mtlo_busy2", 64'(sif.busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
